// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Front-end fetch stage. Fetches 128-bit lines (4 instructions)
//                from combinational program memory into a line FIFO, and hands
//                one instruction per cycle, with its PC, to dispatch. A taken
//                jump/branch flushes the queue and restarts fetch at the
//                target, possibly in the middle of a line.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,            // asynchronous, active-low
    output logic [31:0]  p_mem_add,
    input  logic [127:0] p_mem_data,
    input  logic         jmp_br_valid,
    input  logic [31:0]  jmp_br_addr,
    input  logic         dispatch_rd_en,
    output logic [31:0]  ifq_inst,
    output logic [31:0]  ifq_pc,
    output logic [31:0]  ifq_pc_plus4,
    output logic         ifq_empty
);

    // Pointer width and count width (count must also represent DEPTH itself)
    localparam int             c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------------
    logic [127:0]         r_data [DEPTH];
    logic [27:0]          r_addr [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [1:0]           r_rd_off;
    logic [27:0]          r_fetch_pc;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_en;
    logic                 w_pop;
    logic                 w_free;
    logic [127:0]         w_head_data;
    logic [27:0]          w_head_addr;
    logic [31:0]          w_head_word;
    logic [31:0]          w_head_pc;
    logic [c_CNT_W-1:0]   w_count_nxt;

    // Fullness is judged on the count held before this edge, so a pop that
    // frees an entry cannot also make room for a write in the same cycle.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A redirect overrides both the write and the pop of this cycle.
    assign w_wr_en = !w_full && !jmp_br_valid;
    assign w_pop   = dispatch_rd_en && !w_empty && !jmp_br_valid;
    assign w_free  = w_pop && (r_rd_off == 2'd3);

    // Occupancy update: a write and a freeing pop in the same cycle cancel.
    always_comb begin
        w_count_nxt = r_count;
        if (jmp_br_valid) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_en, w_free})
                2'b10:   w_count_nxt = r_count + c_CNT_1;
                2'b01:   w_count_nxt = r_count - c_CNT_1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers: pointers, occupancy, word offset, fetch address
    // ------------------------------------------------------------------------
    // Sequential control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_off   <= 2'd0;
            r_fetch_pc <= RESET_PC[31:4];
        end else begin
            r_count <= w_count_nxt;
            if (jmp_br_valid) begin
                // Flush and restart at the target; the target word offset
                // selects where consumption of the first line begins.
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_rd_off   <= jmp_br_addr[3:2];
                r_fetch_pc <= jmp_br_addr[31:4];
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_fetch_pc <= r_fetch_pc + 28'd1;
                end
                if (w_pop) begin
                    if (w_free) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_rd_off <= 2'd0;
                    end else begin
                        r_rd_off <= r_rd_off + 2'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line storage: data arrays carry no reset; validity is tracked by count.
    // ------------------------------------------------------------------------
    // Capture the fetched line and its line address at the write pointer.
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_data[r_wr_ptr] <= p_mem_data;
            r_addr[r_wr_ptr] <= r_fetch_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------------
    assign w_head_data = r_data[r_rd_ptr];
    assign w_head_addr = r_addr[r_rd_ptr];
    assign w_head_word = w_head_data[{r_rd_off, 5'b00000} +: 32];
    assign w_head_pc   = {w_head_addr, r_rd_off, 2'b00};

    // Present the head instruction; all-zero outputs while the queue is empty.
    always_comb begin
        ifq_inst     = 32'd0;
        ifq_pc       = 32'd0;
        ifq_pc_plus4 = 32'd0;
        if (!w_empty) begin
            ifq_inst     = w_head_word;
            ifq_pc       = w_head_pc;
            ifq_pc_plus4 = w_head_pc + 32'd4;
        end
    end

    assign ifq_empty = w_empty;
    assign p_mem_add = {r_fetch_pc, 4'b0000};

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Self-checking bench for instr_fetch_queue. A queue-of-lines
//                reference model predicts the head instruction, PC, empty
//                flag and fetch address after every clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk;
    logic         rst;
    logic [31:0]  p_mem_add;
    logic [127:0] p_mem_data;
    logic         jmp_br_valid;
    logic [31:0]  jmp_br_addr;
    logic         dispatch_rd_en;
    logic [31:0]  ifq_inst;
    logic [31:0]  ifq_pc;
    logic [31:0]  ifq_pc_plus4;
    logic         ifq_empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO is a queue of line addresses, plus the word
    // offset into the head line and the next line to fetch.
    logic [27:0] mq[$];
    logic [1:0]  m_off;
    logic [27:0] m_fetch;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .p_mem_add      (p_mem_add),
        .p_mem_data     (p_mem_data),
        .jmp_br_valid   (jmp_br_valid),
        .jmp_br_addr    (jmp_br_addr),
        .dispatch_rd_en (dispatch_rd_en),
        .ifq_inst       (ifq_inst),
        .ifq_pc         (ifq_pc),
        .ifq_pc_plus4   (ifq_pc_plus4),
        .ifq_empty      (ifq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: the word at byte address a holds 0x1000 + a/4.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0000_1000 + {2'b00, a[31:2]};
    endfunction

    always_comb begin
        p_mem_data = {rom(p_mem_add + 32'd12), rom(p_mem_add + 32'd8),
                      rom(p_mem_add + 32'd4),  rom(p_mem_add)};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_off   = 2'd0;
        m_fetch = RESET_PC[31:4];
    endtask

    // One clock edge of the behavioural model.
    task automatic model_edge(input logic rd, input logic j, input logic [31:0] a);
        bit was_full;
        if (j) begin
            mq.delete();
            m_fetch = a[31:4];
            m_off   = a[3:2];
        end else begin
            was_full = (mq.size() == DEPTH);
            if (rd && mq.size() > 0) begin
                if (m_off == 2'd3) begin
                    void'(mq.pop_front());
                    m_off = 2'd0;
                end else begin
                    m_off = m_off + 2'd1;
                end
            end
            if (!was_full) begin
                mq.push_back(m_fetch);
                m_fetch = m_fetch + 28'd1;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_p4;
        logic        e_empty;
        e_empty = (mq.size() == 0);
        e_pc    = 32'd0;
        e_inst  = 32'd0;
        e_p4    = 32'd0;
        if (!e_empty) begin
            e_pc   = {mq[0], m_off, 2'b00};
            e_inst = rom(e_pc);
            e_p4   = e_pc + 32'd4;
        end
        chk("ifq_empty",    {31'd0, ifq_empty}, {31'd0, e_empty});
        chk("ifq_inst",     ifq_inst,     e_inst);
        chk("ifq_pc",       ifq_pc,       e_pc);
        chk("ifq_pc_plus4", ifq_pc_plus4, e_p4);
        chk("p_mem_add",    p_mem_add,    {m_fetch, 4'b0000});
    endtask

    // Drive inputs, take one edge, advance the model and compare 1ns later.
    task automatic step(input logic rd, input logic j, input logic [31:0] a);
        dispatch_rd_en = rd;
        jmp_br_valid   = j;
        jmp_br_addr    = a;
        @(posedge clk);
        model_edge(rd, j, a);
        #1;
        check_all();
    endtask

    initial begin
        logic        r_rd;
        logic        r_j;
        logic [31:0] r_a;

        rst            = 1'b0;
        dispatch_rd_en = 1'b0;
        jmp_br_valid   = 1'b0;
        jmp_br_addr    = 32'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Reset and streaming
        step(1'b1, 1'b0, 32'd0);
        chk("first_pc", ifq_pc, RESET_PC);
        repeat (20) step(1'b1, 1'b0, 32'd0);

        // Full / backpressure
        step(1'b0, 1'b1, 32'd0);
        repeat (10) step(1'b0, 1'b0, 32'd0);
        chk("stall_p_mem_add", p_mem_add, 32'h0000_0040);
        repeat (16) step(1'b1, 1'b0, 32'd0);

        // Mid-line redirect
        step(1'b1, 1'b1, 32'h0000_0128);
        chk("redir_bubble", {31'd0, ifq_empty}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk("redir_pc", ifq_pc, 32'h0000_0128);
        repeat (8) step(1'b1, 1'b0, 32'd0);

        // Redirect priority with count == 3, pop and pending write
        step(1'b0, 1'b1, 32'd0);
        repeat (3) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_0200);
        chk("prio_empty", {31'd0, ifq_empty}, 32'd1);
        repeat (6) step(1'b1, 1'b0, 32'd0);

        // Empty pop and address wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0);
        chk("wrap_pc",    ifq_pc,       32'hFFFF_FFFC);
        chk("wrap_plus4", ifq_pc_plus4, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        chk("wrap_next_pc", ifq_pc, 32'h0000_0000);
        repeat (4) step(1'b1, 1'b0, 32'd0);

        // Randomized traffic
        repeat (400) begin
            r_rd = ($urandom_range(0, 3) != 0);
            r_j  = ($urandom_range(0, 15) == 0);
            r_a  = $urandom;
            if ($urandom_range(0, 3) == 0) r_a[31:8] = 24'hFF_FFFF;
            step(r_rd, r_j, r_a);
        end

        // Asynchronous reset between edges
        repeat (3) step(1'b1, 1'b0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        repeat (8) step(1'b1, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Front-end fetch stage of `tomasulo_cpu`, directly upstream of the dispatch/issue logic. It fetches 128-bit lines of four instructions from combinational program memory and buffers them in a line FIFO. It presents one 32-bit instruction per cycle, with its PC, to dispatch. Taken jumps and branches flush the queue and redirect fetch, starting mid-line where required.

## Interface
- `DEPTH`, 4: number of 128-bit line entries; power of 2, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; must be 16-byte aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock domain only.
- `p_mem_add`  out  32  program memory line address, always `{fetch_pc[31:4], 4'b0}`.
- `p_mem_data`  in  128  line data, valid combinationally in the same cycle; instruction k is at bits [32k+31:32k].
- `jmp_br_valid`  in  1  redirect request, single-cycle pulse from the branch/jump unit.
- `jmp_br_addr`  in  32  redirect target; bits [1:0] are ignored.
- `dispatch_rd_en`  in  1  pop the head instruction.
- `ifq_inst`  out  32  head instruction.
- `ifq_pc`  out  32  PC of the head instruction.
- `ifq_pc_plus4`  out  32  `ifq_pc + 4`, modulo 2^32.
- `ifq_empty`  out  1  no valid instruction at the head.

## Operation
- State:
  - line FIFO of `DEPTH` entries, each holding {128-bit data, line address[31:4]};
  - `wr_ptr` / `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - `count`, 0..DEPTH;
  - `rd_off`, 2-bit word offset within the head line;
  - `fetch_pc`, 28-bit line address.
- Write: when `count < DEPTH` and no redirect:
  - store `{p_mem_data, fetch_pc}` at `wr_ptr`;
  - `wr_ptr++`;
  - `fetch_pc++`, wrapping 0xFFFFFFF → 0.
- Fullness is judged on `count` before this edge's pop. At `count == DEPTH`, no write occurs even if a pop frees an entry that cycle.
- Read outputs:
  - `ifq_inst` = word `rd_off` of the head line;
  - `ifq_pc` = `{head_addr, rd_off, 2'b00}`.
- Pop: `dispatch_rd_en` with `ifq_empty == 0`.
  - If `rd_off == 3`: `rd_ptr++`, `rd_off = 0`, and the entry is freed.
  - Otherwise: `rd_off++`.
- Pop while empty is ignored; no state change.
- Simultaneous write and freeing pop: `count` unchanged.
- Redirect (`jmp_br_valid == 1`) has priority over both pop and write:
  - `count = 0`, `wr_ptr = rd_ptr = 0`;
  - `fetch_pc = jmp_br_addr[31:4]`;
  - `rd_off = jmp_br_addr[3:2]`, so the first line after redirect is consumed from that word.
- `ifq_empty = (count == 0)`. While empty, `ifq_inst`, `ifq_pc` and `ifq_pc_plus4` are driven to 0.

## Timing
- Reset, asynchronous on `rst == 0`:
  - `fetch_pc = RESET_PC[31:4]`, so `p_mem_add = RESET_PC`;
  - `count = 0`, pointers 0, `rd_off = 0`;
  - `ifq_empty = 1`, `ifq_inst = ifq_pc = ifq_pc_plus4 = 0`.
- First edge after `rst` rises: line `RESET_PC` is written. One cycle after release, `ifq_empty = 0` and `ifq_pc = RESET_PC`.
- Write-to-visible latency is 1 cycle. Pop takes effect at the edge, and the next instruction is visible immediately after.
- Steady-state throughput is 1 instruction/cycle. Fetch bandwidth is 4/cycle, so the queue fills when dispatch stalls.
- Redirect at edge N:
  - cycle N+1: `ifq_empty = 1`, `p_mem_add` = target line;
  - edge N+1: target line written;
  - cycle N+2: target instruction visible.
  - Net bubble is 1 cycle.
- Redirect on the same edge as a pop: the pop is discarded.
- Reset asserted mid-operation clears all state immediately; no partial write completes.

## Test plan
- **Reset and streaming:** reset with `RESET_PC = 0`, ROM holding words 0x1000+k, `dispatch_rd_en = 1` continuously. Expect `ifq_empty` to fall 1 cycle after release, then `ifq_inst` = 0x1000, 0x1001, … one per cycle, with `ifq_pc` = 0, 4, 8, … and `ifq_pc_plus4` = `ifq_pc + 4`.
- **Full / backpressure:** `dispatch_rd_en = 0` for 10 cycles. `count` saturates at `DEPTH` = 4 and `p_mem_add` stops at 0x40. Release the stall: 16 instructions come out in order with no loss or duplication.
- **Mid-line redirect:** pulse `jmp_br_valid` with `jmp_br_addr = 0x0000_0128`. Expect `ifq_empty = 1` for one cycle, then `ifq_pc` = 0x128, 0x12C, 0x130, … with instructions from words 2, 3 of line 0x120 and then line 0x130.
- **Redirect priority:** assert redirect together with a pop and a pending write while `count = 3`. The queue flushes to `count = 0` and no stale instruction appears afterwards.
- **Empty pop and wrap:** pop while empty leaves the state unchanged. Redirect to 0xFFFF_FFFC: the next instruction after it has `ifq_pc` = 0x0000_0000, and `ifq_pc_plus4` at 0xFFFF_FFFC equals 0.
- **Async reset mid-stream:** drop `rst` between edges. Outputs go to their reset values without waiting for `clk`.
